// File: rtl/sparse_sel_gen_pkg.sv
// sparsynergy_pkg: shared types and constants for the 2:4 sparsity selection path.
//   ACT_W_DEF / W_W_DEF : default activation / weight widths
//   IDX_W               : position index width inside a 4-wide group
//   group_t             : one compressed group (4 acts, 2 weights, 2 indices)
//   state_t             : beat sequencer states
package sparsynergy_pkg;

    localparam int ACT_W_DEF = 8;
    localparam int W_W_DEF   = 8;
    localparam int IDX_W     = 2;

    typedef struct packed {
        logic [3:0][ACT_W_DEF-1:0] act;
        logic [W_W_DEF-1:0]        w1;
        logic [W_W_DEF-1:0]        w0;
        logic [IDX_W-1:0]          idx1;
        logic [IDX_W-1:0]          idx0;
    } group_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

endpackage

// File: rtl/sparse_sel_gen_if.sv
// sparse_sel_gen_if: group input bus, beat output bus and the sticky error flag.
//   master : upstream producer + downstream consumer side (drives in_*, out_ready)
//   slave  : sparse_sel_gen side (drives in_ready, out_*, meta_err)
interface sparse_sel_gen_if
    import sparsynergy_pkg::*;
#(
    parameter int ACT_W = ACT_W_DEF,
    parameter int W_W   = W_W_DEF
);

    logic             in_valid;
    logic             in_ready;
    logic [ACT_W-1:0] in_act0;
    logic [ACT_W-1:0] in_act1;
    logic [ACT_W-1:0] in_act2;
    logic [ACT_W-1:0] in_act3;
    logic [W_W-1:0]   in_w0;
    logic [W_W-1:0]   in_w1;
    logic [IDX_W-1:0] in_idx0;
    logic [IDX_W-1:0] in_idx1;

    logic             out_valid;
    logic             out_ready;
    logic [ACT_W-1:0] out_act0;
    logic [ACT_W-1:0] out_act1;
    logic [ACT_W-1:0] out_act2;
    logic [ACT_W-1:0] out_act3;
    logic [IDX_W-1:0] out_sel;
    logic [W_W-1:0]   out_w;
    logic             out_last;

    logic             meta_err;

    modport master (
        output in_valid, in_act0, in_act1, in_act2, in_act3,
               in_w0, in_w1, in_idx0, in_idx1, out_ready,
        input  in_ready, out_valid, out_act0, out_act1, out_act2, out_act3,
               out_sel, out_w, out_last, meta_err
    );

    modport slave (
        input  in_valid, in_act0, in_act1, in_act2, in_act3,
               in_w0, in_w1, in_idx0, in_idx1, out_ready,
        output in_ready, out_valid, out_act0, out_act1, out_act2, out_act3,
               out_sel, out_w, out_last, meta_err
    );

endinterface

// File: rtl/sparse_sel_gen_fifo.sv
// sync_fifo_grp: synchronous FIFO holding packed group records.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   push_i, data_i   : write strobe and record (caller guarantees !full_o)
//   pop_i, data_o    : read strobe (caller guarantees !empty_o); data_o shows the head
//   full_o, empty_o  : occupancy flags, decoded from the registered count only
module sync_fifo_grp #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
        end
    end

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/sparse_sel_gen.sv
// sparse_sel_gen: buffers compressed 2:4 groups and replays each over two beats
// (idx0/w0 then idx1/w1) toward the 4:1 activation mux and MAC.
//   clk, rst  : clock, synchronous active-high reset
//   bus.in_*  : group input handshake (in_ready = buffer not full)
//   bus.out_* : registered beat output; out_last flags the final beat of a K-group run
//   bus.meta_err : sticky flag for a group arriving with idx0 >= idx1
module sparse_sel_gen
    import sparsynergy_pkg::*;
#(
    parameter int ACT_W      = ACT_W_DEF,
    parameter int W_W        = W_W_DEF,
    parameter int K_GROUPS   = 16,
    parameter int FIFO_DEPTH = 2
) (
    input logic            clk,
    input logic            rst,
    sparse_sel_gen_if.slave bus
);

    localparam int CNT_W = (K_GROUPS > 1) ? $clog2(K_GROUPS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(K_GROUPS - 1);

    typedef struct packed {
        logic [3:0][ACT_W-1:0] act;
        logic [W_W-1:0]        w1;
        logic [W_W-1:0]        w0;
        logic [IDX_W-1:0]      idx1;
        logic [IDX_W-1:0]      idx0;
    } grp_t;

    grp_t push_grp;
    grp_t head_grp;
    logic push;
    logic load;
    logic fifo_full;
    logic fifo_empty;

    state_t                state_q, state_d;
    logic [3:0][ACT_W-1:0] act_q, act_d;
    logic [IDX_W-1:0]      sel_q, sel_d;
    logic [W_W-1:0]        w_q, w_d;
    logic [IDX_W-1:0]      idx1_q, idx1_d;
    logic [W_W-1:0]        w1_q, w1_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  meta_q;

    assign push_grp.act  = {bus.in_act3, bus.in_act2, bus.in_act1, bus.in_act0};
    assign push_grp.w1   = bus.in_w1;
    assign push_grp.w0   = bus.in_w0;
    assign push_grp.idx1 = bus.in_idx1;
    assign push_grp.idx0 = bus.in_idx0;

    assign bus.in_ready = !fifo_full;
    assign push         = bus.in_valid && !fifo_full;

    sync_fifo_grp #(
        .WIDTH ($bits(grp_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .data_i  (push_grp),
        .pop_i   (load),
        .data_o  (head_grp),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            act_q   <= '0;
            sel_q   <= '0;
            w_q     <= '0;
            idx1_q  <= '0;
            w1_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            meta_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            sel_q   <= sel_d;
            w_q     <= w_d;
            idx1_q  <= idx1_d;
            w1_q    <= w1_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            if (push && (bus.in_idx0 >= bus.in_idx1)) meta_q <= 1'b1;
        end
    end

    // Output registers are computed one cycle ahead so every out_* is a flop;
    // 'load' (the FIFO pop) is shared by the IDLE start and the BEAT1 back-to-back path.
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        sel_d   = sel_q;
        w_d     = w_q;
        idx1_d  = idx1_q;
        w1_d    = w1_q;
        valid_d = valid_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) load = 1'b1;
            end
            BEAT0: begin
                if (bus.out_ready) begin
                    state_d = BEAT1;
                    sel_d   = idx1_q;
                    w_d     = w1_q;
                    last_d  = (cnt_q == CNT_MAX);
                end
            end
            BEAT1: begin
                if (bus.out_ready) begin
                    cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
                    last_d = 1'b0;
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        if (load) begin
            state_d = BEAT0;
            act_d   = head_grp.act;
            sel_d   = head_grp.idx0;
            w_d     = head_grp.w0;
            idx1_d  = head_grp.idx1;
            w1_d    = head_grp.w1;
            valid_d = 1'b1;
            last_d  = 1'b0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_act0  = act_q[0];
    assign bus.out_act1  = act_q[1];
    assign bus.out_act2  = act_q[2];
    assign bus.out_act3  = act_q[3];
    assign bus.out_sel   = sel_q;
    assign bus.out_w     = w_q;
    assign bus.out_last  = last_q;
    assign bus.meta_err  = meta_q;

endmodule

// File: tb/tb_sparse_sel_gen.sv
// Bench for sparse_sel_gen with K_GROUPS = 4 and a 2-deep buffer. Inputs change
// 1 time unit after posedge; outputs are observed on negedge. A monitor pops the
// expected-beat queue for every accepted beat.
module tb_sparse_sel_gen;
    import sparsynergy_pkg::*;

    localparam int K = 4;

    typedef struct packed {
        logic [31:0] acts;
        logic [1:0]  sel;
        logic [7:0]  w;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sparse_sel_gen_if #(.ACT_W(8), .W_W(8)) bus ();

    sparse_sel_gen #(
        .ACT_W      (8),
        .W_W        (8),
        .K_GROUPS   (K),
        .FIFO_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    int    model_cnt = 0;
    beat_t sb[$];
    int    bcyc[$];
    logic  blast[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: each accepted beat must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            beat_t got;
            beat_t exp;
            got = {bus.out_act3, bus.out_act2, bus.out_act1, bus.out_act0,
                   bus.out_sel, bus.out_w, bus.out_last};
            bcyc.push_back(cyc);
            blast.push_back(bus.out_last);
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL beat_unexpected: got %h, none expected", got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp)
                    $display("FAIL beat: got acts=%h sel=%0d w=%h last=%b, expected acts=%h sel=%0d w=%h last=%b",
                             got.acts, got.sel, got.w, got.last, exp.acts, exp.sel, exp.w, exp.last);
                else
                    n_pass++;
            end
        end
    end

    function automatic group_t mk(input logic [7:0] a0, a1, a2, a3,
                                  input logic [7:0] w0, w1,
                                  input logic [1:0] i0, i1);
        group_t g;
        g.act  = {a3, a2, a1, a0};
        g.w0   = w0;
        g.w1   = w1;
        g.idx0 = i0;
        g.idx1 = i1;
        return g;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        sb.delete();
        bcyc.delete();
        blast.delete();
        model_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drives one group until accepted, then queues its two expected beats.
    task automatic push_group(input group_t g);
        bit done;
        done = 1'b0;
        bus.in_act0 = g.act[0];
        bus.in_act1 = g.act[1];
        bus.in_act2 = g.act[2];
        bus.in_act3 = g.act[3];
        bus.in_w0   = g.w0;
        bus.in_w1   = g.w1;
        bus.in_idx0 = g.idx0;
        bus.in_idx1 = g.idx1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (!done) begin
            $display("FAIL push_timeout: in_ready never high within 50 cycles, required 1");
        end else begin
            n_pass++;
            sb.push_back('{acts: g.act, sel: g.idx0, w: g.w0, last: 1'b0});
            sb.push_back('{acts: g.act, sel: g.idx1, w: g.w1, last: (model_cnt == K-1)});
            model_cnt = (model_cnt + 1) % K;
        end
    endtask

    task automatic wait_idle(input int budget);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < budget && !idle; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) idle = 1'b1;
        end
        n_checks++;
        if (!idle) $display("FAIL drain_timeout: %0d beats still pending, required 0", sb.size());
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); else n_pass++;
        n_checks++; if ({bus.out_act3, bus.out_act2, bus.out_act1, bus.out_act0} !== 32'h0)
            $display("FAIL rst_out_act: got %h required 0", {bus.out_act3, bus.out_act2, bus.out_act1, bus.out_act0}); else n_pass++;
        n_checks++; if (bus.out_sel !== 2'd0) $display("FAIL rst_out_sel: got %0d required 0", bus.out_sel); else n_pass++;
        n_checks++; if (bus.out_w !== 8'h00) $display("FAIL rst_out_w: got %h required 00", bus.out_w); else n_pass++;
        n_checks++; if (bus.out_last !== 1'b0) $display("FAIL rst_out_last: got %b required 0", bus.out_last); else n_pass++;
        n_checks++; if (bus.meta_err !== 1'b0) $display("FAIL rst_meta_err: got %b required 0", bus.meta_err); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b required 1", bus.in_ready); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        bcyc.delete();
        push_group(mk(8'd10, 8'd20, 8'd30, 8'd40, 8'd5, 8'hFE, 2'd1, 2'd3));
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_latency_n1: got out_valid %b required 0", bus.out_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL single_latency_n2: got out_valid %b required 1", bus.out_valid); else n_pass++;
        wait_idle(20);
        n_checks++; if (bcyc.size() != 2) $display("FAIL single_beats: got %0d beats required 2", bcyc.size()); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] a_acts;
        a_acts = {8'd4, 8'd3, 8'd2, 8'd1};
        bus.out_ready = 1'b0;
        bcyc.delete();
        push_group(mk(8'd1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd9, 2'd0, 2'd2));
        push_group(mk(8'd11, 8'd12, 8'd13, 8'd14, 8'h21, 8'h22, 2'd1, 2'd2));
        push_group(mk(8'd21, 8'd22, 8'd23, 8'd24, 8'h31, 8'h32, 2'd0, 2'd3));
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_full: got in_ready %b required 0", bus.in_ready); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if ({bus.out_valid, bus.out_act3, bus.out_act2, bus.out_act1, bus.out_act0, bus.out_sel, bus.out_w, bus.out_last}
                !== {1'b1, a_acts, 2'd0, 8'd7, 1'b0})
                $display("FAIL bp_hold%0d: got v=%b acts=%h sel=%0d w=%h last=%b, required v=1 acts=%h sel=0 w=07 last=0",
                         i, bus.out_valid, {bus.out_act3, bus.out_act2, bus.out_act1, bus.out_act0},
                         bus.out_sel, bus.out_w, bus.out_last, a_acts);
            else n_pass++;
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_idle(40);
        n_checks++; if (bcyc.size() != 6) $display("FAIL bp_beats: got %0d beats required 6", bcyc.size()); else n_pass++;
    endtask

    task automatic test_streaming();
        int bubbles;
        int bad_last;
        do_reset();
        bus.out_ready = 1'b1;
        for (int g = 0; g < K + 1; g++)
            push_group(mk(8'(g), 8'(g + 50), 8'(g + 100), 8'(g + 150), 8'(g + 1), 8'(g + 2), 2'd0, 2'd1));
        wait_idle(40);
        n_checks++;
        if (bcyc.size() != 10) begin
            $display("FAIL stream_beats: got %0d beats required 10", bcyc.size());
        end else begin
            n_pass++;
            bubbles = 0;
            bad_last = 0;
            for (int i = 1; i < 10; i++) if (bcyc[i] != bcyc[i-1] + 1) bubbles++;
            for (int i = 0; i < 8; i++) if (blast[i] !== (i == 7)) bad_last++;
            n_checks++; if (bubbles != 0) $display("FAIL stream_bubbles: got %0d gaps required 0", bubbles); else n_pass++;
            n_checks++; if (bad_last != 0) $display("FAIL stream_last: got %0d misplaced last flags required 0", bad_last); else n_pass++;
            n_checks++; if (blast[9] !== 1'b0) $display("FAIL stream_next_run_last: got %b required 0", blast[9]); else n_pass++;
        end
    endtask

    task automatic test_meta();
        do_reset();
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.meta_err !== 1'b0) $display("FAIL meta_before: got %b required 0", bus.meta_err); else n_pass++;
        @(posedge clk); #1;
        push_group(mk(8'd7, 8'd8, 8'd9, 8'd10, 8'h33, 8'h44, 2'd2, 2'd2));
        @(negedge clk);
        n_checks++; if (bus.meta_err !== 1'b1) $display("FAIL meta_rise: got %b required 1", bus.meta_err); else n_pass++;
        @(posedge clk); #1;
        wait_idle(20);
        n_checks++; if (bus.meta_err !== 1'b1) $display("FAIL meta_sticky: got %b required 1", bus.meta_err); else n_pass++;
    endtask

    task automatic test_rst_mid();
        int bad_last;
        do_reset();
        bus.out_ready = 1'b1;
        push_group(mk(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 2'd0, 2'd1));
        wait_idle(20);
        bus.out_ready = 1'b0;
        push_group(mk(8'd90, 8'd91, 8'd92, 8'd93, 8'h55, 8'h66, 2'd3, 2'd1));
        push_group(mk(8'd80, 8'd81, 8'd82, 8'd83, 8'h77, 8'h88, 2'd0, 2'd2));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid, bus.out_sel, bus.out_w, bus.meta_err} !== {1'b1, 2'd1, 8'h66, 1'b1})
            $display("FAIL rstmid_beat1: got v=%b sel=%0d w=%h meta=%b required v=1 sel=1 w=66 meta=1",
                     bus.out_valid, bus.out_sel, bus.out_w, bus.meta_err);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        model_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        bcyc.delete();
        blast.delete();
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b required 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b required 1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.meta_err !== 1'b0) $display("FAIL rstmid_meta: got %b required 0", bus.meta_err); else n_pass++;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int g = 0; g < K; g++)
            push_group(mk(8'(g + 3), 8'(g + 4), 8'(g + 5), 8'(g + 6), 8'(g + 9), 8'(g + 10), 2'd1, 2'd2));
        wait_idle(40);
        n_checks++;
        if (blast.size() != 2 * K) begin
            $display("FAIL rstmid_beats: got %0d beats required %0d", blast.size(), 2 * K);
        end else begin
            bad_last = 0;
            for (int i = 0; i < 2 * K; i++) if (blast[i] !== (i == 2 * K - 1)) bad_last++;
            if (bad_last != 0) $display("FAIL rstmid_last: got %0d misplaced last flags required 0", bad_last);
            else n_pass++;
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_act0 = '0; bus.in_act1 = '0; bus.in_act2 = '0; bus.in_act3 = '0;
        bus.in_w0 = '0; bus.in_w1 = '0; bus.in_idx0 = '0; bus.in_idx1 = '0;

        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_meta();
        test_rst_mid();

        n_checks++;
        if (sb.size() != 0) $display("FAIL final_scoreboard: got %0d pending beats required 0", sb.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
